// File: rtl/alu_bist_scheduler.sv
// Online BIST sequencer for the primary ALU: schedules sessions, handshakes a
// pipeline stall, walks 8 test vectors and latches a sticky fault on mismatch.
module alu_bist_scheduler #(
  parameter int PERIOD      = 1024,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bist_enable,
  input  logic             bist_start,
  input  logic             stall_ack,
  input  logic             clear_fault,
  input  logic [31:0]      alu_result,
  output logic             stall_req,
  output logic             test_en,
  output logic [2:0]       test_counter,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             fault_latched,
  output logic [2:0]       fault_vector,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] skip_count
);

  localparam int INT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(PERIOD - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_TEST     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  function automatic logic [31:0] golden(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: golden = 32'hFFFF_FFFF;
      3'd4:                   golden = 32'h0000_0000;
      3'd5:                   golden = 32'hFFFF_FFFF;
      3'd6:                   golden = 32'hAAAA_AAAB;
      3'd7:                   golden = 32'h0000_0001;
      default:                golden = 32'h0000_0000;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [INT_W-1:0] int_cnt_r, int_cnt_s;
  logic [ACK_W-1:0] ack_cnt_r, ack_cnt_s;
  logic             sess_mis_r, sess_mis_s;
  logic             stall_req_r, stall_req_s;
  logic             test_en_r, test_en_s;
  logic [2:0]       test_counter_r, test_counter_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             fault_r, fault_s;
  logic [2:0]       fault_vec_r, fault_vec_s;
  logic [CNT_W-1:0] pass_cnt_r, pass_cnt_s;
  logic [CNT_W-1:0] skip_cnt_r, skip_cnt_s;
  logic             mismatch_s;
  logic             trigger_s;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s        = state_r;
    int_cnt_s      = int_cnt_r;
    ack_cnt_s      = ack_cnt_r;
    sess_mis_s     = sess_mis_r;
    stall_req_s    = 1'b0;
    test_en_s      = 1'b0;
    test_counter_s = 3'd0;
    done_s         = 1'b0;
    fault_s        = fault_r;
    fault_vec_s    = fault_vec_r;
    pass_cnt_s     = pass_cnt_r;
    skip_cnt_s     = skip_cnt_r;
    mismatch_s     = (state_r == S_TEST) && (alu_result != golden(test_counter_r));
    trigger_s      = !fault_r &&
                     (bist_start || (bist_enable && (int_cnt_r == INT_LAST)));

    case (state_r)
      S_IDLE: begin
        if (trigger_s) begin
          state_s     = S_WAIT_ACK;
          stall_req_s = 1'b1;
          int_cnt_s   = {INT_W{1'b0}};
          ack_cnt_s   = {ACK_W{1'b0}};
        end else if (bist_enable && !fault_r) begin
          int_cnt_s = int_cnt_r + INT_W'(1'b1);
        end else begin
          int_cnt_s = int_cnt_r;
        end
      end
      S_WAIT_ACK: begin
        if (stall_ack) begin
          state_s     = S_TEST;
          stall_req_s = 1'b1;
          test_en_s   = 1'b1;
          sess_mis_s  = 1'b0;
        end else if (ack_cnt_r == ACK_LAST) begin
          // Hazard unit never drained: abandon quietly, no done pulse.
          state_s = S_IDLE;
          if (skip_cnt_r != CNT_MAX) begin
            skip_cnt_s = skip_cnt_r + CNT_W'(1'b1);
          end else begin
            skip_cnt_s = skip_cnt_r;
          end
        end else begin
          stall_req_s = 1'b1;
          ack_cnt_s   = ack_cnt_r + ACK_W'(1'b1);
        end
      end
      S_TEST: begin
        sess_mis_s = sess_mis_r | mismatch_s;
        if (test_counter_r == 3'd7) begin
          state_s = S_DONE;
          done_s  = 1'b1;
          if (!(sess_mis_r || mismatch_s) && (pass_cnt_r != CNT_MAX)) begin
            pass_cnt_s = pass_cnt_r + CNT_W'(1'b1);
          end else begin
            pass_cnt_s = pass_cnt_r;
          end
        end else begin
          stall_req_s    = 1'b1;
          test_en_s      = 1'b1;
          test_counter_s = test_counter_r + 3'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // A mismatch outranks a simultaneous clear so a real fault is never lost.
    if (mismatch_s) begin
      fault_s = 1'b1;
      if (!fault_r || clear_fault) begin
        fault_vec_s = test_counter_r;
      end else begin
        fault_vec_s = fault_vec_r;
      end
    end else if (clear_fault) begin
      fault_s     = 1'b0;
      fault_vec_s = 3'd0;
    end else begin
      fault_s     = fault_r;
      fault_vec_s = fault_vec_r;
    end

    busy_s = (state_s != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      int_cnt_r      <= {INT_W{1'b0}};
      ack_cnt_r      <= {ACK_W{1'b0}};
      sess_mis_r     <= 1'b0;
      stall_req_r    <= 1'b0;
      test_en_r      <= 1'b0;
      test_counter_r <= 3'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      fault_r        <= 1'b0;
      fault_vec_r    <= 3'd0;
      pass_cnt_r     <= {CNT_W{1'b0}};
      skip_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r        <= state_s;
      int_cnt_r      <= int_cnt_s;
      ack_cnt_r      <= ack_cnt_s;
      sess_mis_r     <= sess_mis_s;
      stall_req_r    <= stall_req_s;
      test_en_r      <= test_en_s;
      test_counter_r <= test_counter_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
      fault_r        <= fault_s;
      fault_vec_r    <= fault_vec_s;
      pass_cnt_r     <= pass_cnt_s;
      skip_cnt_r     <= skip_cnt_s;
    end
  end

  assign stall_req     = stall_req_r;
  assign test_en       = test_en_r;
  assign test_counter  = test_counter_r;
  assign bist_busy     = busy_r;
  assign bist_done     = done_r;
  assign fault_latched = fault_r;
  assign fault_vector  = fault_vec_r;
  assign pass_count    = pass_cnt_r;
  assign skip_count    = skip_cnt_r;

endmodule

// File: tb/tb_alu_bist_scheduler.sv
// Directed bench for alu_bist_scheduler (PERIOD=8, ACK_TIMEOUT=16); outputs are
// sampled on the falling edge and inputs are changed there too.
module tb_alu_bist_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        bist_enable, bist_start, clear_fault;
  logic        stall_ack;
  logic [31:0] alu_result;
  logic        stall_req, test_en, bist_busy, bist_done, fault_latched;
  logic [2:0]  test_counter, fault_vector;
  logic [7:0]  pass_count, skip_count;

  logic        ack_mode, ack_d;
  logic        inj_en;
  logic [2:0]  inj_idx;
  logic [31:0] inj_val;

  int n_checks = 0;
  int n_fail   = 0;

  alu_bist_scheduler #(.PERIOD(8), .ACK_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bist_enable(bist_enable), .bist_start(bist_start),
    .stall_ack(stall_ack), .clear_fault(clear_fault), .alu_result(alu_result),
    .stall_req(stall_req), .test_en(test_en), .test_counter(test_counter),
    .bist_busy(bist_busy), .bist_done(bist_done), .fault_latched(fault_latched),
    .fault_vector(fault_vector), .pass_count(pass_count), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  // Healthy ALU answers for each test vector, from the golden table.
  function automatic logic [31:0] healthy_alu(input logic [2:0] idx);
    case (idx)
      3'd4:    healthy_alu = 32'h0000_0000;
      3'd6:    healthy_alu = 32'hAAAA_AAAB;
      3'd7:    healthy_alu = 32'h0000_0001;
      default: healthy_alu = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign alu_result = (inj_en && (test_counter == inj_idx)) ? inj_val : healthy_alu(test_counter);

  // Hazard unit model: acknowledges one cycle after the request.
  always @(posedge clk) ack_d <= stall_req;
  assign stall_ack = ack_mode & ack_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bist_enable = 1'b0; bist_start = 1'b0; clear_fault = 1'b0;
    ack_mode = 1'b1; ack_d = 1'b0; inj_en = 1'b0; inj_idx = 3'd0; inj_val = 32'd0;
    repeat (2) step();
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_test_en", 32'(test_en), 32'd0);
    chk("rst_busy", 32'(bist_busy), 32'd0);
    chk("rst_done", 32'(bist_done), 32'd0);
    chk("rst_fault", 32'(fault_latched), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_skip", 32'(skip_count), 32'd0);

    // Periodic session with healthy ALU: request appears on cycle 8.
    rst = 1'b0; bist_enable = 1'b1;
    repeat (7) step();
    chk("t1_pre_stall", 32'(stall_req), 32'd0);
    step();
    chk("t1_stall", 32'(stall_req), 32'd1);
    chk("t1_busy", 32'(bist_busy), 32'd1);
    chk("t1_no_test_en", 32'(test_en), 32'd0);
    step();
    chk("t1_wait_stall", 32'(stall_req), 32'd1);
    chk("t1_wait_test_en", 32'(test_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t1_tc%0d", i), 32'(test_counter), 32'(i));
      chk($sformatf("t1_en%0d", i), 32'(test_en), 32'd1);
      chk($sformatf("t1_stall%0d", i), 32'(stall_req), 32'd1);
      chk($sformatf("t1_done%0d", i), 32'(bist_done), 32'd0);
    end
    step();
    chk("t1_done", 32'(bist_done), 32'd1);
    chk("t1_done_test_en", 32'(test_en), 32'd0);
    chk("t1_done_stall", 32'(stall_req), 32'd0);
    chk("t1_done_tc", 32'(test_counter), 32'd0);
    chk("t1_pass", 32'(pass_count), 32'd1);
    chk("t1_fault", 32'(fault_latched), 32'd0);
    bist_enable = 1'b0;
    step();
    chk("t1_done_drop", 32'(bist_done), 32'd0);
    chk("t1_idle", 32'(bist_busy), 32'd0);

    // Manual session, vector 2 returns zero.
    inj_en = 1'b1; inj_idx = 3'd2; inj_val = 32'h0000_0000; bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    chk("t2_stall", 32'(stall_req), 32'd1);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2_tc%0d", i), 32'(test_counter), 32'(i));
      chk($sformatf("t2_fault%0d", i), 32'(fault_latched), (i >= 3) ? 32'd1 : 32'd0);
    end
    step();
    chk("t2_done", 32'(bist_done), 32'd1);
    chk("t2_pass", 32'(pass_count), 32'd1);
    chk("t2_fault", 32'(fault_latched), 32'd1);
    chk("t2_fvec", 32'(fault_vector), 32'd2);
    step();
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    chk("t2_blocked_stall", 32'(stall_req), 32'd0);
    chk("t2_blocked_busy", 32'(bist_busy), 32'd0);
    step();
    chk("t2_blocked_stall2", 32'(stall_req), 32'd0);
    inj_en = 1'b0;

    // Clear, then a session whose ack never arrives.
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("t3_cleared", 32'(fault_latched), 32'd0);
    chk("t3_cleared_vec", 32'(fault_vector), 32'd0);
    ack_mode = 1'b0; bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    chk("t3_stall0", 32'(stall_req), 32'd1);
    for (int j = 1; j < 16; j++) begin
      step();
      chk($sformatf("t3_stall%0d", j), 32'(stall_req), 32'd1);
      chk($sformatf("t3_done%0d", j), 32'(bist_done), 32'd0);
    end
    step();
    chk("t3_stall_drop", 32'(stall_req), 32'd0);
    chk("t3_idle", 32'(bist_busy), 32'd0);
    chk("t3_skip", 32'(skip_count), 32'd1);
    chk("t3_no_done", 32'(bist_done), 32'd0);

    // Manual start lands on the periodic expiry cycle.
    ack_mode = 1'b1; bist_enable = 1'b1;
    repeat (7) step();
    chk("t4_pre_stall", 32'(stall_req), 32'd0);
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    chk("t4_stall", 32'(stall_req), 32'd1);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t4_tc%0d", i), 32'(test_counter), 32'(i));
    end
    step();
    chk("t4_done", 32'(bist_done), 32'd1);
    chk("t4_pass", 32'(pass_count), 32'd2);
    step();
    chk("t4_single", 32'(bist_busy), 32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("t4_gap%0d", k), 32'(stall_req), 32'd0);
    end
    step();
    chk("t4_next_period", 32'(stall_req), 32'd1);

    // Mismatch at vector 6 together with clear_fault.
    bist_enable = 1'b0; inj_en = 1'b1; inj_idx = 3'd6; inj_val = 32'hAAAA_AAAA;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t5_tc%0d", i), 32'(test_counter), 32'(i));
      if (i == 7) begin
        clear_fault = 1'b0;
        chk("t5_fault_kept", 32'(fault_latched), 32'd1);
        chk("t5_fvec", 32'(fault_vector), 32'd6);
      end else begin
        chk($sformatf("t5_fault%0d", i), 32'(fault_latched), 32'd0);
        if (i == 6) clear_fault = 1'b1;
      end
    end
    step();
    chk("t5_done", 32'(bist_done), 32'd1);
    chk("t5_pass", 32'(pass_count), 32'd2);
    step();
    inj_en = 1'b0; clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("t5_clear", 32'(fault_latched), 32'd0);
    chk("t5_clear_vec", 32'(fault_vector), 32'd0);
    bist_enable = 1'b1;
    repeat (7) step();
    chk("t5_resume_pre", 32'(stall_req), 32'd0);
    step();
    chk("t5_resume", 32'(stall_req), 32'd1);

    // Asynchronous reset in the middle of vector 4.
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t6_tc%0d", i), 32'(test_counter), 32'(i));
    end
    chk("t6_test_en_before", 32'(test_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_test_en", 32'(test_en), 32'd0);
    chk("t6_stall", 32'(stall_req), 32'd0);
    chk("t6_busy", 32'(bist_busy), 32'd0);
    chk("t6_pass", 32'(pass_count), 32'd0);
    chk("t6_tc", 32'(test_counter), 32'd0);
    step();
    rst = 1'b0; bist_enable = 1'b0;
    step();
    chk("t6_idle", 32'(bist_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
